// File: rtl/interrupt_controller_pkg.sv
// -----------------------------------------------------------------------------
// interrupt_controller_pkg
// Shared definitions for the interrupt controller slice:
//   - state_t     : FSM state encoding (IDLE, REQ, SERVICE)
//   - NSRC        : number of device interrupt sources
//   - *_IDN       : device ID numbers reported on idn (index + 1, 0 = none)
//   - idn_of()    : maps a source index to its device ID number
// No ports (package).
// -----------------------------------------------------------------------------
package interrupt_controller_pkg;

  localparam int NSRC = 4;

  localparam int TIMER_IDN = 1;
  localparam int KEYS_IDN  = 2;
  localparam int SW_IDN    = 3;
  localparam int SPARE_IDN = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Device IDs are one-based so that zero can mean "no source".
  function automatic int idn_of(input int idx);
    return idx + 1;
  endfunction

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// -----------------------------------------------------------------------------
// interrupt_controller_priority_encoder
// Fixed-priority encoder: the lowest set bit of the eligible vector wins.
// Ports:
//   eligible  in   NSRC   candidate sources (pending & mask)
//   idx       out  IDXW   index of the winning source (0 when none)
//   valid     out  1      at least one source is eligible
// -----------------------------------------------------------------------------
module interrupt_controller_priority_encoder #(
  parameter int NSRC = 4,
  parameter int IDXW = 2
) (
  input  logic [NSRC-1:0] eligible,
  output logic [IDXW-1:0] idx,
  output logic            valid
);

  // Scan from the highest index down so the lowest set bit is written last.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        idx   = IDXW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
// Edge-triggered, non-nesting interrupt controller. Rising edges on irq set
// pending bits; the highest-priority (lowest index) enabled pending source is
// latched and presented to the CPU until it is accepted, then the controller
// waits in SERVICE until return-from-interrupt.
// Ports:
//   clk      in   1      clock, rising edge
//   reset    in   1      asynchronous active-high reset
//   irq      in   NSRC   device request lines (edge-sensitive)
//   irqMask  in   NSRC   per-source enable
//   intaSig  in   1      CPU accepted the interrupt this cycle
//   isReti   in   1      CPU executing return-from-interrupt this cycle
//   inta     out  1      interrupt request (high only in REQ)
//   idn      out  DBITS  device ID of the requested source, 0 = none
//   devAck   out  NSRC   one-cycle acknowledge to the serviced device
//   pending  out  NSRC   current pending bits
// -----------------------------------------------------------------------------
module interrupt_controller #(
  parameter int DBITS = 32,
  parameter int NSRC  = interrupt_controller_pkg::NSRC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NSRC-1:0]  irq,
  input  logic [NSRC-1:0]  irqMask,
  input  logic             intaSig,
  input  logic             isReti,
  output logic             inta,
  output logic [DBITS-1:0] idn,
  output logic [NSRC-1:0]  devAck,
  output logic [NSRC-1:0]  pending
);

  import interrupt_controller_pkg::*;

  localparam int IDXW = (NSRC > 1) ? $clog2(NSRC) : 1;

  state_t            state;
  logic [NSRC-1:0]   irq_prev;
  logic [NSRC-1:0]   pend_q;
  logic [NSRC-1:0]   dev_ack_q;
  logic [NSRC-1:0]   rise;
  logic [NSRC-1:0]   eligible;
  logic [IDXW-1:0]   sel_idx;
  logic              sel_valid;
  logic [IDXW-1:0]   latched_idx;
  logic              inta_q;
  logic [DBITS-1:0]  idn_q;

  assign rise     = irq & ~irq_prev;
  assign eligible = pend_q & irqMask;

  interrupt_controller_priority_encoder #(
    .NSRC (NSRC),
    .IDXW (IDXW)
  ) u_priority_encoder (
    .eligible (eligible),
    .idx      (sel_idx),
    .valid    (sel_valid)
  );

  // Edge capture, pending bookkeeping and the IDLE/REQ/SERVICE FSM share one
  // process because acceptance clears pending in the same edge it changes
  // state; a fresh edge on the accepted source is OR-ed in after the clear so
  // that a set always wins over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      irq_prev    <= '0;
      pend_q      <= '0;
      dev_ack_q   <= '0;
      latched_idx <= '0;
      inta_q      <= 1'b0;
      idn_q       <= '0;
    end else begin
      irq_prev  <= irq;
      pend_q    <= pend_q | rise;
      dev_ack_q <= '0;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            state       <= REQ;
            latched_idx <= sel_idx;
            inta_q      <= 1'b1;
            idn_q       <= DBITS'(idn_of(int'(sel_idx)));
          end
        end
        // The latched request stays up until accepted, regardless of mask
        // changes or newly pending higher-priority sources.
        REQ: begin
          if (intaSig) begin
            state     <= SERVICE;
            inta_q    <= 1'b0;
            idn_q     <= '0;
            dev_ack_q <= NSRC'(1) << latched_idx;
            pend_q    <= (pend_q & ~(NSRC'(1) << latched_idx)) | rise;
          end
        end
        SERVICE: begin
          if (isReti) begin
            state <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          inta_q <= 1'b0;
          idn_q  <= '0;
        end
      endcase
    end
  end

  assign inta    = inta_q;
  assign idn     = idn_q;
  assign devAck  = dev_ack_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
// Self-checking bench for interrupt_controller: a table of per-cycle vectors
// plus hand-written sequences for the long hold and asynchronous reset cases.
// Expected outputs are queued when a cycle's stimulus is driven and popped
// and compared after the following rising edge.
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

  import interrupt_controller_pkg::*;

  localparam int DBITS = 32;
  localparam int NS    = 4;

  typedef struct {
    logic [NS-1:0] irq;
    logic [NS-1:0] msk;
    logic          ack;
    logic          reti;
    logic          e_inta;
    int            e_idn;
    logic [NS-1:0] e_dev;
    logic [NS-1:0] e_pend;
  } vec_t;

  typedef struct {
    logic          inta;
    int            idn;
    logic [NS-1:0] dev;
    logic [NS-1:0] pend;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [NS-1:0]    irq;
  logic [NS-1:0]    irqMask;
  logic             intaSig;
  logic             isReti;
  logic             inta;
  logic [DBITS-1:0] idn;
  logic [NS-1:0]    devAck;
  logic [NS-1:0]    pending;

  int   total;
  int   bad;
  int   step_no;
  vec_t vecs[$];
  exp_t sb[$];

  interrupt_controller #(
    .DBITS (DBITS),
    .NSRC  (NS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .irq     (irq),
    .irqMask (irqMask),
    .intaSig (intaSig),
    .isReti  (isReti),
    .inta    (inta),
    .idn     (idn),
    .devAck  (devAck),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s step=%0d: actual=%0h required=%0h", name, step_no, act, exp);
    end
  endtask

  task automatic add(input logic [NS-1:0] i, input logic [NS-1:0] m, input logic a,
                     input logic r, input logic ei, input int eidn,
                     input logic [NS-1:0] ed, input logic [NS-1:0] ep);
    vec_t v;
    v.irq = i; v.msk = m; v.ack = a; v.reti = r;
    v.e_inta = ei; v.e_idn = eidn; v.e_dev = ed; v.e_pend = ep;
    vecs.push_back(v);
  endtask

  // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    exp_t got;
    irq     = v.irq;
    irqMask = v.msk;
    intaSig = v.ack;
    isReti  = v.reti;
    e.inta = v.e_inta; e.idn = v.e_idn; e.dev = v.e_dev; e.pend = v.e_pend;
    sb.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      check("inta",    32'(inta),    32'(got.inta));
      check("idn",     idn,          32'(got.idn));
      check("devAck",  32'(devAck),  32'(got.dev));
      check("pending", 32'(pending), 32'(got.pend));
    end
  endtask

  task automatic cyc(input logic [NS-1:0] i, input logic [NS-1:0] m, input logic a,
                     input logic r, input logic ei, input int eidn,
                     input logic [NS-1:0] ed, input logic [NS-1:0] ep);
    vec_t v;
    v.irq = i; v.msk = m; v.ack = a; v.reti = r;
    v.e_inta = ei; v.e_idn = eidn; v.e_dev = ed; v.e_pend = ep;
    applyStimulus(v);
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_inta"},    32'(inta),    32'd0);
    check({tag, "_idn"},     idn,          32'd0);
    check({tag, "_devAck"},  32'(devAck),  32'd0);
    check({tag, "_pending"}, 32'(pending), 32'd0);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    step_no = 0;
    reset   = 1'b1;
    irq     = '0;
    irqMask = 4'hF;
    intaSig = 1'b0;
    isReti  = 1'b0;

    // Single edge on keys: pend, request, accept, ack pulse, return
    add(4'b0010, 4'hF, 0, 0, 0, 0,         4'b0000, 4'b0010);
    add(4'b0010, 4'hF, 0, 0, 1, KEYS_IDN,  4'b0000, 4'b0010);
    add(4'b0010, 4'hF, 1, 0, 0, 0,         4'b0010, 4'b0000);
    add(4'b0010, 4'hF, 0, 0, 0, 0,         4'b0000, 4'b0000);
    add(4'b0000, 4'hF, 0, 1, 0, 0,         4'b0000, 4'b0000);
    // Simultaneous keys + spare: keys first, spare after return
    add(4'b1010, 4'hF, 0, 0, 0, 0,         4'b0000, 4'b1010);
    add(4'b1010, 4'hF, 0, 0, 1, KEYS_IDN,  4'b0000, 4'b1010);
    add(4'b1010, 4'hF, 1, 0, 0, 0,         4'b0010, 4'b1000);
    add(4'b1010, 4'hF, 0, 0, 0, 0,         4'b0000, 4'b1000);
    add(4'b1010, 4'hF, 0, 1, 0, 0,         4'b0000, 4'b1000);
    add(4'b1010, 4'hF, 0, 0, 1, SPARE_IDN, 4'b0000, 4'b1000);
    add(4'b1010, 4'hF, 1, 0, 0, 0,         4'b1000, 4'b0000);
    add(4'b0000, 4'hF, 0, 1, 0, 0,         4'b0000, 4'b0000);
    // Switch edge during SERVICE is held off until return
    add(4'b0001, 4'hF, 0, 0, 0, 0,         4'b0000, 4'b0001);
    add(4'b0001, 4'hF, 0, 0, 1, TIMER_IDN, 4'b0000, 4'b0001);
    add(4'b0001, 4'hF, 1, 0, 0, 0,         4'b0001, 4'b0000);
    add(4'b0101, 4'hF, 0, 0, 0, 0,         4'b0000, 4'b0100);
    add(4'b0101, 4'hF, 0, 0, 0, 0,         4'b0000, 4'b0100);
    add(4'b0101, 4'hF, 0, 1, 0, 0,         4'b0000, 4'b0100);
    add(4'b0101, 4'hF, 0, 0, 1, SW_IDN,    4'b0000, 4'b0100);
    add(4'b0101, 4'hF, 1, 0, 0, 0,         4'b0100, 4'b0000);
    add(4'b0000, 4'hF, 0, 1, 0, 0,         4'b0000, 4'b0000);
    // Timer re-edge coincident with acceptance: set wins, second delivery
    add(4'b0001, 4'hF, 0, 0, 0, 0,         4'b0000, 4'b0001);
    add(4'b0000, 4'hF, 0, 0, 1, TIMER_IDN, 4'b0000, 4'b0001);
    add(4'b0001, 4'hF, 1, 0, 0, 0,         4'b0001, 4'b0001);
    add(4'b0001, 4'hF, 0, 0, 0, 0,         4'b0000, 4'b0001);
    add(4'b0001, 4'hF, 0, 1, 0, 0,         4'b0000, 4'b0001);
    add(4'b0001, 4'hF, 0, 0, 1, TIMER_IDN, 4'b0000, 4'b0001);
    add(4'b0000, 4'hF, 1, 0, 0, 0,         4'b0001, 4'b0000);
    add(4'b0000, 4'hF, 0, 1, 0, 0,         4'b0000, 4'b0000);
    // Masked pending, stray ack/reti in IDLE, masking during REQ
    add(4'b0100, 4'h0, 0, 0, 0, 0,         4'b0000, 4'b0100);
    add(4'b0100, 4'h0, 1, 1, 0, 0,         4'b0000, 4'b0100);
    add(4'b0100, 4'h4, 0, 0, 1, SW_IDN,    4'b0000, 4'b0100);
    add(4'b0100, 4'h0, 0, 1, 1, SW_IDN,    4'b0000, 4'b0100);
    add(4'b0100, 4'h0, 1, 0, 0, 0,         4'b0100, 4'b0000);
    add(4'b0000, 4'hF, 0, 1, 0, 0,         4'b0000, 4'b0000);

    // Reset state
    #2;
    checkOutput("reset_async");
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset_hold");
    reset = 1'b0;

    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
    end

    // Long hold without acceptance while a higher-priority source arrives
    $display("[TB] long hold sequence");
    cyc(4'b0100, 4'hF, 0, 0, 0, 0,      4'b0000, 4'b0100);
    cyc(4'b0100, 4'hF, 0, 0, 1, SW_IDN, 4'b0000, 4'b0100);
    for (int i = 0; i < 20; i++) begin
      cyc((i >= 5) ? 4'b0101 : 4'b0100, 4'hF, 0, 0, 1, SW_IDN, 4'b0000,
          (i >= 5) ? 4'b0101 : 4'b0100);
    end
    cyc(4'b0101, 4'hF, 1, 0, 0, 0,         4'b0100, 4'b0001);
    cyc(4'b0101, 4'hF, 0, 1, 0, 0,         4'b0000, 4'b0001);
    cyc(4'b0101, 4'hF, 0, 0, 1, TIMER_IDN, 4'b0000, 4'b0001);
    cyc(4'b0101, 4'hF, 1, 0, 0, 0,         4'b0001, 4'b0000);
    cyc(4'b0000, 4'hF, 0, 1, 0, 0,         4'b0000, 4'b0000);

    // Asynchronous reset in the middle of a request
    $display("[TB] reset mid-request sequence");
    cyc(4'b0010, 4'hF, 0, 0, 0, 0,        4'b0000, 4'b0010);
    cyc(4'b0010, 4'hF, 0, 0, 1, KEYS_IDN, 4'b0000, 4'b0010);
    #2;
    reset = 1'b1;
    irq   = '0;
    #1;
    checkOutput("reset_midreq");
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(4'b0000, 4'hF, 0, 0, 0, 0,        4'b0000, 4'b0000);
    cyc(4'b0000, 4'hF, 0, 0, 0, 0,        4'b0000, 4'b0000);
    cyc(4'b0010, 4'hF, 0, 0, 0, 0,        4'b0000, 4'b0010);
    cyc(4'b0010, 4'hF, 0, 0, 1, KEYS_IDN, 4'b0000, 4'b0010);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
